// File: rtl/rf_write_arbiter_if.sv
// ---------------------------------------------------------------------------
// rf_write_arbiter_if
//   Bundles the two requester handshakes and the register-file write port
//   owned by rf_write_arbiter.
//
//   Handshake: a requester raises reqN_valid with reqN_addr/reqN_data stable;
//   the write is accepted on the rising clk edge where reqN_valid && reqN_ready
//   are both high. Valid may be dropped before ready (nothing is written);
//   otherwise valid, addr and data must be held until ready.
//
//   master : requester side (drives valid/addr/data, observes ready and the
//            write port).
//   slave  : arbiter side (drives ready, rf_D/rf_DA/rf_RW, grant_id,
//            init_done).
// ---------------------------------------------------------------------------
interface rf_write_arbiter_if #(
   parameter int DW = 16,
   parameter int AW = 4
);
   logic          req0_valid;
   logic [AW-1:0] req0_addr;
   logic [DW-1:0] req0_data;
   logic          req0_ready;
   logic          req1_valid;
   logic [AW-1:0] req1_addr;
   logic [DW-1:0] req1_data;
   logic          req1_ready;
   logic [DW-1:0] rf_D;
   logic [AW-1:0] rf_DA;
   logic          rf_RW;
   logic          grant_id;
   logic          init_done;

   modport master (
      output req0_valid, req0_addr, req0_data,
      output req1_valid, req1_addr, req1_data,
      input  req0_ready, req1_ready,
      input  rf_D, rf_DA, rf_RW, grant_id, init_done
   );

   modport slave (
      input  req0_valid, req0_addr, req0_data,
      input  req1_valid, req1_addr, req1_data,
      output req0_ready, req1_ready,
      output rf_D, rf_DA, rf_RW, grant_id, init_done
   );
endinterface

// File: rtl/rf_write_arbiter.sv
// ---------------------------------------------------------------------------
// rf_write_arbiter
//   Owns the single write port (D/DA/RW) of the register file. After reset a
//   hardware INIT sequence writes zero to all 2**AW registers, one per clock,
//   addresses ascending. Afterwards two requesters (req0 = ALU writeback,
//   req1 = load unit) share the port under round-robin arbitration.
//
//   Ports:
//     clk       rising-edge clock, shared with the register file
//     reset     asynchronous, active-low reset
//     bus       rf_write_arbiter_if.slave: requester handshakes + write port
//     state_dbg current FSM state (0 = INIT, 1 = RUN)
//
//   Write-port outputs are registered: a handshake on edge N makes rf_RW
//   visible after edge N; the register file stores it on edge N+1.
//
//   Optional build macro: RF_R0_HARDWIRE_EN
//     Register 0 is constant zero. Handshakes to address 0 are accepted as
//     usual (ready, grant_id, round-robin pointer all update) but rf_RW stays
//     low for that cycle. INIT still clears register 0.
// ---------------------------------------------------------------------------
module rf_write_arbiter #(
   parameter int DW = 16,
   parameter int AW = 4
) (
   input  logic              clk,
   input  logic              reset,
   rf_write_arbiter_if.slave bus,
   output logic [0:0]        state_dbg
);

   localparam logic [0:0]    ST_INIT  = 1'b0;
   localparam logic [0:0]    ST_RUN   = 1'b1;
   localparam logic [AW-1:0] CNT_LAST = {AW{1'b1}};
   localparam logic [AW-1:0] CNT_ONE  = AW'(1);

   logic [0:0]    state;
   logic [AW-1:0] cnt;
   logic          lp;        // requester granted last; the other wins a tie
   logic          run;
   logic          gnt0;
   logic          gnt1;
   logic          hs_id;
   logic [AW-1:0] hs_addr;
   logic [DW-1:0] hs_data;
   logic          hs_write;

   // Readiness depends on reset directly so both readies drop the instant
   // reset is asserted, not on the next edge.
   always_comb begin
      run  = reset && (state == ST_RUN);
      gnt0 = run && bus.req0_valid && (!bus.req1_valid || lp);
      gnt1 = run && bus.req1_valid && (!bus.req0_valid || !lp);
   end

   assign bus.req0_ready = gnt0;
   assign bus.req1_ready = gnt1;
   assign state_dbg      = state;

   // Winner's payload; only meaningful when gnt0 || gnt1.
   always_comb begin
      hs_id   = gnt1;
      hs_addr = gnt1 ? bus.req1_addr : bus.req0_addr;
      hs_data = gnt1 ? bus.req1_data : bus.req0_data;
`ifdef RF_R0_HARDWIRE_EN
      hs_write = (hs_addr != '0);
`else
      hs_write = 1'b1;
`endif
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state         <= ST_INIT;
         cnt           <= '0;
         lp            <= 1'b1;
         bus.rf_RW     <= 1'b0;
         bus.rf_DA     <= '0;
         bus.rf_D      <= '0;
         bus.grant_id  <= 1'b0;
         bus.init_done <= 1'b0;
      end else begin
         case (state)
            ST_INIT: begin
               // Clear one register per clock; the last clear and
               // init_done become visible together.
               bus.rf_RW <= 1'b1;
               bus.rf_DA <= cnt;
               bus.rf_D  <= '0;
               cnt       <= cnt + CNT_ONE;
               if (cnt == CNT_LAST) begin
                  state         <= ST_RUN;
                  bus.init_done <= 1'b1;
               end
            end
            default: begin
               if (gnt0 || gnt1) begin
                  bus.rf_RW    <= hs_write;
                  bus.rf_DA    <= hs_addr;
                  bus.rf_D     <= hs_data;
                  bus.grant_id <= hs_id;
                  lp           <= hs_id;
               end else begin
                  bus.rf_RW <= 1'b0;
               end
            end
         endcase
      end
   end

endmodule

// File: doc/rf_write_arbiter.md
Name: rf_write_arbiter

Overview:
- Owns the single write port (D/DA/RW) of the 16x16 register file.
- After reset, a hardware INIT sequence zeroes all 16 registers.
- Afterwards, writes from two requesters (ALU writeback = req0, load unit = req1) share the port under round-robin arbitration with a valid/ready handshake.
- Write-port outputs are registered and drive the register file directly.

Parameters:
- DW, 16, data width; matches the register file word.
- AW, 4, register address width; 2**AW registers are cleared in INIT.

Ports:
- clk  in  1  rising-edge clock, shared with the register file.
- reset  in  1  asynchronous, active-low reset.
- req0_valid  in  1  requester 0 has a write pending.
- req0_addr  in  AW  requester 0 destination register.
- req0_data  in  DW  requester 0 write data.
- req0_ready  out  1  requester 0 write accepted this cycle (combinational).
- req1_valid  in  1  requester 1 has a write pending.
- req1_addr  in  AW  requester 1 destination register.
- req1_data  in  DW  requester 1 write data.
- req1_ready  out  1  requester 1 write accepted this cycle (combinational).
- rf_D  out  DW  to register file D.
- rf_DA  out  AW  to register file DA.
- rf_RW  out  1  to register file RW.
- grant_id  out  1  requester that produced the current rf_RW pulse (0/1).
- init_done  out  1  high once INIT completes.

Behaviour:
- Reset (reset=0, async), all registered outputs cleared:
  - rf_RW=0, rf_DA=0, rf_D=0, grant_id=0, init_done=0.
  - State=INIT, clear counter cnt=0, last-grant pointer lp=1 (so req0 wins the first tie).
- Ready outputs are 0 whenever reset=0 or state=INIT.
- Reset asserted mid-operation aborts any write in flight and restarts INIT; in-flight requester data is not retained.
- State INIT:
  - Each clock: rf_RW<=1, rf_DA<=cnt, rf_D<=0, cnt<=cnt+1.
  - On the edge where cnt==2**AW-1, state<=RUN and init_done<=1.
  - Result: exactly 16 consecutive RW pulses, addresses 0..15 in order; the first pulse is visible in the cycle after the first post-reset edge.
  - Requester valids are ignored; requesters simply hold valid (no loss).
- State RUN, arbitration (combinational from valids and lp):
  - Only req0_valid: req0_ready=1.
  - Only req1_valid: req1_ready=1.
  - Both valid: grant req(~lp); the other ready=0.
  - Neither valid: both ready=0.
  - At most one ready is high in any cycle.
- State RUN, handshake (valid&&ready at posedge):
  - rf_RW<=1, rf_DA<=addr, rf_D<=data, grant_id<=i, lp<=i.
  - Latency: 1 cycle from handshake edge to RW visible; the register file stores on the following edge.
  - Back-to-back handshakes are allowed: one write per cycle, 100% port utilisation.
- State RUN, no handshake: rf_RW<=0; rf_DA, rf_D, grant_id hold their values.
- Fairness: under continuous dual requests grants alternate 0,1,0,1…; neither requester waits more than 1 cycle.
- Requester rules:
  - Must hold valid, addr and data stable until ready.
  - Deasserting valid without ready is legal; nothing is written.
- Same address from both requesters in consecutive grants: both writes are issued in grant order, and the last write wins.
- No read-side control: A/B read ports remain driven by the datapath.

Optional Feature:
- Macro: RF_R0_HARDWIRE_EN.
- When defined:
  - Register 0 is treated as constant zero.
  - Handshakes with addr==0 are accepted normally (ready, lp update, grant_id update) but rf_RW<=0 for that cycle.
  - INIT still clears register 0.
- When undefined: address 0 is an ordinary writable register.

Test Plan:
- Reset then release, no requests -> rf_RW high 16 consecutive cycles with rf_DA 0..15 and rf_D=0; init_done rises with the last pulse; readies 0 throughout.
- After INIT, req0 only, addr=3, data=16'hBEEF -> req0_ready=1 same cycle; next cycle rf_RW=1, rf_DA=3, rf_D=16'hBEEF, grant_id=0.
- Both valid continuously for 6 cycles (req0 addr=1 data=16'h1111, req1 addr=2 data=16'h2222), each valid dropped after its handshake and re-raised next cycle -> grants 0,1,0,1,0,1; rf_RW high every cycle; never both ready.
- req1 valid (addr=5) during INIT -> req1_ready=0 until the cycle after init_done; then the write to 5 is issued; no write lost.
- reset asserted while state=RUN with handshakes in progress -> outputs clear immediately (async, no clock); INIT restarts at rf_DA=0.
- With RF_R0_HARDWIRE_EN, req0 addr=0 data=16'hFFFF -> ready=1, rf_RW stays 0; without the macro -> rf_RW=1, rf_DA=0, rf_D=16'hFFFF.
